imm_decode_pipe: RTL and testbench
==================================

# imm_decode_pipe

Registered, handshaked immediate generator for the decode stage. Accepts one 32-bit RV instruction per cycle, classifies its immediate format, and returns the fully assembled, sign-extended XLEN-bit immediate, with the bit swizzles for B and J applied. A two-entry skid buffer gives a registered `in_ready`, so the block sits between fetch and the register-read stage without a combinational ready path.

## Interface
- `XLEN`, 32: immediate/data width. Legal values are 32 and 64.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: the instruction on `in_instr` is valid.
- `in_ready` out 1: the block can accept an instruction; registered.
- `in_instr` in 32: raw instruction word.
- `out_valid` out 1: the output bundle is valid.
- `out_ready` in 1: the consumer accepts the output bundle.
- `out_imm` out XLEN: assembled immediate.
- `out_fmt` out 3: format code. 0 = NONE, 1 = I, 2 = S, 3 = B, 4 = U, 5 = J, 6 = Z (CSR zimm). Codes 7 and above are unused.
- `out_illegal` out 1: unrecognised opcode, or `instr[1:0]` is not 2'b11.
- `out_instr` out 32: the instruction word, passed through unchanged.

## Operation
- **Opcode map:**
  - I: 0010011, 0000011, 1100111, 0001111, 1110011.
  - I, only when `XLEN`=64: 0011011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - NONE: 0110011.
  - NONE, only when `XLEN`=64: 0111011.
  - Any other opcode gives NONE with `out_illegal`=1. So does `instr[1:0]`≠2'b11.
- **Immediate assembly** (msb of the immediate field sign-extended to `XLEN`):
  - I: `instr[31:20]`.
  - S: {`instr[31:25]`, `instr[11:7]`}.
  - B: {`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 1'b0}.
  - U: {`instr[31:12]`, 12'b0}, sign-extended from bit 31.
  - J: {`instr[31]`, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 1'b0}.
  - NONE and illegal: 0.
- **Datapath:** decode is combinational into the pipeline registers. There is one main output register plus one skid register.
- **Accept:** an input is accepted when `in_valid` && `in_ready`.
- **Output state:**
  - Output empty, or `out_ready`=1: the accepted item loads the main register.
  - Main register full and `out_ready`=0: the accepted item loads the skid register.
- **Skid drain:** on `out_ready`=1 with the skid full, the skid moves to the main register. Strict FIFO order is kept.
- **Ready:** `in_ready` is the registered value of !skid_valid. No item is ever dropped or duplicated.
- **Stall:** while `out_valid`=1 && `out_ready`=0, all `out_*` fields hold stable.

## Timing
- **Latency:** 1 cycle from accept to `out_valid`. Throughput is 1 per cycle with `out_ready` held high.
- **Reset values:**
  - `out_valid`=0, `out_imm`=0, `out_fmt`=0, `out_illegal`=0, `out_instr`=0.
  - Skid register empty.
  - `in_ready`=1 from the first cycle after `rst` deasserts.
- **Reset behaviour:**
  - An input presented in a cycle with `rst`=1 is discarded.
  - Reset mid-stall flushes both entries.
- **Skid full:** `in_ready`=0 on the cycle after the skid fills. It returns to 1 on the cycle after the skid drains.
- **Simultaneous events:**
  - Accept and drain in the same cycle with the skid empty: the new item replaces the main register, so there is no bubble.
  - Accept and drain with the skid full is impossible, because `in_ready`=0.

## Configuration
- **`IMM_DECODE_ZICSR_EN` defined:** for opcode 1110011 with `instr[14]`=1, `out_fmt`=Z and `out_imm` is zero-extended `instr[19:15]`.
- **Macro undefined:** the same encodings decode as plain I-format, with the immediate taken from `instr[31:20]`. Code 6 is never produced.

## Test plan
- **Formats, `out_ready`=1:**
  - 0xFFF00093 → `out_imm`=0xFFFFFFFF, fmt I.
  - 0xFE112E23 → 0xFFFFFFFC, fmt S.
  - 0xFE000CE3 → 0xFFFFFFF8, fmt B.
  - 0x123452B7 → 0x12345000, fmt U.
  - 0x001000EF → 0x00000800, fmt J.
  - Each appears 1 cycle after accept.
- **Backpressure:** stream 4 instructions with `out_ready`=0 from cycle 1.
  - `in_ready` falls after 2 accepts and `out_*` hold the first item.
  - Raise `out_ready`: all 4 emerge in order with no gaps or duplicates.
- **Illegal:** 0x00000000 → `out_illegal`=1, fmt NONE, `out_imm`=0. 0x00B50533 (add) → fmt NONE, `out_illegal`=0.
- **CSR immediate:** 0x3002D073 → with the macro, fmt Z and imm 0x5. Without the macro, fmt I and imm 0x300.
- **XLEN=64:** 0xFFF00093 → 0xFFFFFFFFFFFFFFFF. 0x8000029B → fmt I, imm 0xFFFFFFFFFFFFF800.
- **Reset during stall:** both entries full, assert `rst` for 1 cycle → next cycle `out_valid`=0 and `in_ready`=1. No stale item emerges afterwards.

Source files
------------

// File: rtl/imm_decode_pipe.sv
// Decode-stage immediate generator: classifies RV instruction formats and assembles the
// sign-extended immediate behind a main+skid register pair. Optional macro: IMM_DECODE_ZICSR_EN.
module imm_decode_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_instr
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    // Bundle layout: {imm, fmt, illegal, instr}
    localparam int PW = XLEN + 3 + 1 + 32;

    logic [6:0]      opcode_s;
    logic [2:0]      dec_fmt_s;
    logic            dec_illegal_s;
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] dec_imm_s;
    logic [PW-1:0]   dec_bundle_s;

    logic            accept_s;
    logic            load_main_s;
    logic            main_from_skid_s;
    logic            load_skid_s;
    logic            main_valid_nxt_s;
    logic            skid_valid_nxt_s;

    logic            main_valid_r;
    logic            skid_valid_r;
    logic            in_ready_r;
    logic [PW-1:0]   main_r;
    logic [PW-1:0]   skid_r;

    // Opcode classification into immediate format and legality
    always_comb begin
        opcode_s      = in_instr[6:0];
        dec_fmt_s     = FMT_NONE;
        dec_illegal_s = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal_s = 1'b1;
        end else begin
            case (opcode_s)
                7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
                    dec_fmt_s = FMT_I;
                end
                7'b1110011: begin
`ifdef IMM_DECODE_ZICSR_EN
                    if (in_instr[14]) begin
                        dec_fmt_s = FMT_Z;
                    end else begin
                        dec_fmt_s = FMT_I;
                    end
`else
                    dec_fmt_s = FMT_I;
`endif
                end
                7'b0011011: begin
                    if (XLEN == 64) begin
                        dec_fmt_s = FMT_I;
                    end else begin
                        dec_illegal_s = 1'b1;
                    end
                end
                7'b0100011: dec_fmt_s = FMT_S;
                7'b1100011: dec_fmt_s = FMT_B;
                7'b0110111, 7'b0010111: dec_fmt_s = FMT_U;
                7'b1101111: dec_fmt_s = FMT_J;
                7'b0110011: dec_fmt_s = FMT_NONE;
                7'b0111011: begin
                    if (XLEN == 64) begin
                        dec_fmt_s = FMT_NONE;
                    end else begin
                        dec_illegal_s = 1'b1;
                    end
                end
                default: dec_illegal_s = 1'b1;
            endcase
        end
    end

    // Immediate field swizzle, then widen to XLEN (zimm is the only zero-extended form)
    always_comb begin
        imm32_s = 32'd0;
        case (dec_fmt_s)
            FMT_I: imm32_s = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm32_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm32_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: imm32_s = {in_instr[31:12], 12'd0};
            FMT_J: imm32_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            FMT_Z: imm32_s = {27'd0, in_instr[19:15]};
            default: imm32_s = 32'd0;
        endcase
        dec_imm_s        = {XLEN{imm32_s[31] & (dec_fmt_s != FMT_Z)}};
        dec_imm_s[31:0]  = imm32_s;
        dec_bundle_s     = {dec_imm_s, dec_fmt_s, dec_illegal_s, in_instr};
    end

    // Main/skid steering; the skid only drains into main and never coexists with an accept
    always_comb begin
        accept_s         = in_valid & in_ready_r;
        load_main_s      = 1'b0;
        main_from_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        main_valid_nxt_s = main_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (!main_valid_r || out_ready) begin
            if (skid_valid_r) begin
                main_from_skid_s = 1'b1;
                main_valid_nxt_s = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else if (accept_s) begin
                load_main_s      = 1'b1;
                main_valid_nxt_s = 1'b1;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                load_skid_s      = 1'b1;
                skid_valid_nxt_s = 1'b1;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
            end
        end
    end

    // Pipeline state; payload registers only move on a load so stalled outputs hold
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            main_r       <= '0;
            skid_r       <= '0;
        end else begin
            main_valid_r <= main_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            in_ready_r   <= ~skid_valid_nxt_s;
            if (main_from_skid_s) begin
                main_r <= skid_r;
            end else if (load_main_s) begin
                main_r <= dec_bundle_s;
            end else begin
                main_r <= main_r;
            end
            if (load_skid_s) begin
                skid_r <= dec_bundle_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = main_valid_r;
    assign out_imm     = main_r[PW-1 -: XLEN];
    assign out_fmt     = main_r[35:33];
    assign out_illegal = main_r[32];
    assign out_instr   = main_r[31:0];

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed self-checking bench for imm_decode_pipe (XLEN=32 and XLEN=64 instances).
module tb_imm_decode_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [31:0] out_instr;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [31:0] w_in_instr;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [63:0] w_out_imm;
    logic [2:0]  w_out_fmt;
    logic        w_out_illegal;
    logic [31:0] w_out_instr;

    int pass_cnt = 0;
    int total_cnt = 0;

    imm_decode_pipe #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_instr(out_instr)
    );

    imm_decode_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_instr(w_in_instr),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_imm(w_out_imm),
        .out_fmt(w_out_fmt), .out_illegal(w_out_illegal), .out_instr(w_out_instr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF00093; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_instr = 32'd0; w_out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_ctrl: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_imm !== 32'd0 || out_fmt !== 3'd0 || out_illegal !== 1'b0 || out_instr !== 32'd0)
            $display("FAIL reset_data: imm=%h fmt=%0d ill=%b instr=%h, want all 0",
                     out_imm, out_fmt, out_illegal, out_instr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL reset_discard: out_valid=%b, want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_formats();
        logic [31:0] vec [5] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7, 32'h001000EF};
        logic [31:0] eimm [5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800};
        logic [2:0]  efmt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = vec[i];
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_imm !== eimm[i] || out_fmt !== efmt[i] ||
                out_illegal !== 1'b0 || out_instr !== vec[i])
                $display("FAIL fmt_%0d: v=%b imm=%h fmt=%0d ill=%b instr=%h, want 1 %h %0d 0 %h",
                         i, out_valid, out_imm, out_fmt, out_illegal, out_instr, eimm[i], efmt[i], vec[i]);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL fmt_no_dup: out_valid=%b, want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        logic [31:0] vec [4] = '{32'h00000000, 32'h00B50533, 32'h8000029B, 32'h00000001};
        logic        eill [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = vec[i];
            tick();
            total_cnt++;
            if (out_valid !== 1'b1 || out_illegal !== eill[i] || out_fmt !== 3'd0 || out_imm !== 32'd0)
                $display("FAIL illegal_%0d: v=%b ill=%b fmt=%0d imm=%h, want 1 %b 0 0",
                         i, out_valid, out_illegal, out_fmt, out_imm, eill[i]);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_csr();
        logic [2:0]  efmt;
        logic [31:0] eimm;
`ifdef IMM_DECODE_ZICSR_EN
        efmt = 3'd6; eimm = 32'h00000005;
`else
        efmt = 3'd1; eimm = 32'h00000300;
`endif
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h3002D073;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_fmt !== efmt || out_imm !== eimm || out_illegal !== 1'b0)
            $display("FAIL csr_imm: v=%b fmt=%0d imm=%h ill=%b, want 1 %0d %h 0",
                     out_valid, out_fmt, out_imm, out_illegal, efmt, eimm);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] bp [4] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7};
        logic [31:0] seen [4];
        int idx, got, cyc;
        out_ready = 1'b0; in_valid = 1'b1; in_instr = bp[0];
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_instr !== bp[0] || in_ready !== 1'b1)
            $display("FAIL bp_first: v=%b instr=%h rdy=%b, want 1 %h 1", out_valid, out_instr, in_ready, bp[0]);
        else pass_cnt++;
        in_instr = bp[1];
        tick();
        total_cnt++;
        if (in_ready !== 1'b0 || out_instr !== bp[0])
            $display("FAIL bp_skid_full: rdy=%b instr=%h, want 0 %h", in_ready, out_instr, bp[0]);
        else pass_cnt++;
        in_instr = bp[2];
        tick(); tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_instr !== bp[0] || out_imm !== 32'hFFFFFFFF ||
            out_fmt !== 3'd1 || in_ready !== 1'b0)
            $display("FAIL bp_hold: v=%b instr=%h imm=%h fmt=%0d rdy=%b, want 1 %h ffffffff 1 0",
                     out_valid, out_instr, out_imm, out_fmt, in_ready, bp[0]);
        else pass_cnt++;
        out_ready = 1'b1;
        idx = 2; got = 0; cyc = 0;
        while (got < 4 && cyc < 20) begin
            in_valid = (idx < 4);
            in_instr = (idx < 4) ? bp[idx] : 32'd0;
            if (out_valid) begin
                seen[got] = out_instr;
                got++;
            end
            if (in_valid && in_ready) idx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        total_cnt++;
        if (got !== 4 || cyc !== 4)
            $display("FAIL bp_drain_count: got=%0d cycles=%0d, want 4 4", got, cyc);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (seen[k] !== bp[k])
                $display("FAIL bp_order_%0d: got %h, want %h", k, seen[k], bp[k]);
            else pass_cnt++;
        end
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_tail: v=%b rdy=%b, want 0 1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_xlen64();
        logic [31:0] vec [4] = '{32'hFFF00093, 32'h8000029B, 32'hFE000CE3, 32'h00B5053B};
        logic [63:0] eimm [4] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFF800, 64'hFFFFFFFFFFFFFFF8, 64'd0};
        logic [2:0]  efmt [4] = '{3'd1, 3'd1, 3'd3, 3'd0};
        w_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_in_valid = 1'b1; w_in_instr = vec[i];
            tick();
            total_cnt++;
            if (w_out_valid !== 1'b1 || w_out_imm !== eimm[i] || w_out_fmt !== efmt[i] || w_out_illegal !== 1'b0)
                $display("FAIL x64_%0d: v=%b imm=%h fmt=%0d ill=%b, want 1 %h %0d 0",
                         i, w_out_valid, w_out_imm, w_out_fmt, w_out_illegal, eimm[i], efmt[i]);
            else pass_cnt++;
        end
        w_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h123452B7;
        tick();
        in_instr = 32'h001000EF;
        tick();
        total_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL rs_full: rdy=%b v=%b, want 0 1", in_ready, out_valid);
        else pass_cnt++;
        rst = 1'b1; in_instr = 32'hFFF00093;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'd0)
            $display("FAIL rs_flush: v=%b rdy=%b instr=%h, want 0 1 0", out_valid, in_ready, out_instr);
        else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (out_valid !== 1'b0)
                $display("FAIL rs_stale_%0d: out_valid=%b, want 0", i, out_valid);
            else pass_cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_formats();
        test_illegal();
        test_csr();
        test_backpressure();
        test_xlen64();
        test_reset_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
